// File: rtl/enc_seq_pkg.sv
// Shared types and default sizing for the encoder block sequencer.
// Drain lengths are in encoder clock cycles; counter widths must cover DRAIN_LONG-1.
package enc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

  localparam int DRAIN_SHORT_DEF = 1056;
  localparam int DRAIN_LONG_DEF  = 6144;
  localparam int CNT_W_DEF       = 13;
  localparam int MAX_PEND_DEF    = 4;
  localparam int PEND_W_DEF      = 3;
  localparam int BLK_W_DEF       = 8;
  localparam int TIMEOUT_DEF     = 8192;

  localparam logic MODE_SHORT = 1'b0;
  localparam logic MODE_LONG  = 1'b1;

endpackage

// File: rtl/enc_req_queue.sv
// 1-bit-wide synchronous request FIFO with occupancy count; one-cycle push-to-visible.
// Push when full is refused unless a pop in the same cycle frees the slot.
module enc_req_queue
  import enc_seq_pkg::*;
#(
  parameter int DEPTH = MAX_PEND_DEF,
  parameter int CNT_W = PEND_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_dat,
  input  logic             pop,
  output logic             pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_dat = mem_q[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/enc_block_sequencer.sv
// Encoder block sequencer: blk_ready edge -> queued start pulse (2 cycles when idle) -> wait done -> drain window.
// Requests beyond MAX_PEND are dropped and flagged sticky; ENC_WATCHDOG_EN adds a WAIT timeout.
module enc_block_sequencer
  import enc_seq_pkg::*;
#(
  parameter int DRAIN_SHORT = DRAIN_SHORT_DEF,
  parameter int DRAIN_LONG  = DRAIN_LONG_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MAX_PEND    = MAX_PEND_DEF,
  parameter int PEND_W      = PEND_W_DEF,
`ifdef ENC_WATCHDOG_EN
  parameter int TIMEOUT     = TIMEOUT_DEF,
`endif
  parameter int BLK_W       = BLK_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_ready,
  input  logic              length_sel,
  input  logic              enc_done,
  output logic              start_pulse,
  output logic              start_len,
  output logic              drain_rdreq,
  output logic [CNT_W-1:0]  drain_idx,
  output logic              busy,
  output logic [PEND_W-1:0] pend_count,
  output logic [BLK_W-1:0]  blk_count,
  output logic              overflow,
  output logic              timeout_err
);

  seq_state_e       state_q, state_d;
  logic             blk_ready_q;
  logic             start_len_q, start_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             ovf_q, ovf_d;

  logic             req;
  logic             q_pop;
  logic             q_dat;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] drain_last;
  logic             wd_expire;

  assign req = blk_ready & ~blk_ready_q;

  enc_req_queue #(
    .DEPTH (MAX_PEND),
    .CNT_W (PEND_W)
  ) u_req_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (req),
    .push_dat (length_sel),
    .pop      (q_pop),
    .pop_dat  (q_dat),
    .full     (q_full),
    .empty    (q_empty),
    .count    (pend_count)
  );

  assign drain_last = (start_len_q == MODE_LONG) ? CNT_W'(DRAIN_LONG - 1)
                                                 : CNT_W'(DRAIN_SHORT - 1);

  always_comb begin
    state_d     = state_q;
    start_len_d = start_len_q;
    cnt_d       = cnt_q;
    blk_cnt_d   = blk_cnt_q;
    q_pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_pop       = 1'b1;
          start_len_d = q_dat;
          state_d     = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (enc_done) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (wd_expire) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (cnt_q == drain_last) begin
          cnt_d     = '0;
          blk_cnt_d = blk_cnt_q + BLK_W'(1);
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The pop in IDLE frees a slot in the same cycle, so this only flags true drops.
  assign ovf_d = ovf_q | (req & q_full & ~q_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      blk_ready_q <= 1'b1;
      start_len_q <= 1'b0;
      cnt_q       <= '0;
      blk_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_ready_q <= blk_ready;
      start_len_q <= start_len_d;
      cnt_q       <= cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef ENC_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;

  assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_d = '0;
    if (state_q == WAIT) begin
      wd_d = wd_q + WD_W'(1);
    end
    to_d = to_q | ((state_q == WAIT) & ~enc_done & wd_expire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout_err = to_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign start_pulse = (state_q == START);
  assign start_len   = start_len_q;
  assign drain_rdreq = (state_q == DRAIN);
  assign drain_idx   = cnt_q;
  assign busy        = (state_q != IDLE);
  assign blk_count   = blk_cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_enc_block_sequencer.sv
// Randomised scoreboard bench for enc_block_sequencer: expected block modes are queued at
// request time and a negedge monitor checks each start and drain window as the DUT produces them.
module tb_enc_block_sequencer;

  localparam int SHORT_N = 1056;
  localparam int LONG_N  = 6144;
  localparam int TMO     = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        blk_ready;
  logic        length_sel;
  logic        enc_done;
  logic        start_pulse;
  logic        start_len;
  logic        drain_rdreq;
  logic [12:0] drain_idx;
  logic        busy;
  logic [2:0]  pend_count;
  logic [7:0]  blk_count;
  logic        overflow;
  logic        timeout_err;

  enc_block_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .blk_ready   (blk_ready),
    .length_sel  (length_sel),
    .enc_done    (enc_done),
    .start_pulse (start_pulse),
    .start_len   (start_len),
    .drain_rdreq (drain_rdreq),
    .drain_idx   (drain_idx),
    .busy        (busy),
    .pend_count  (pend_count),
    .blk_count   (blk_count),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic sb[$];
  bit   hold_done = 1'b0;
  int   resp_delay = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each start consumes one expected mode, each drain window is measured.
  bit         in_drain = 1'b0;
  int         dcnt, idx_bad, last_idx;
  logic       cur_mode = 1'b0;
  logic [7:0] exp_blk = '0;

  always @(negedge clk) begin
    if (reset) begin
      in_drain = 1'b0;
      exp_blk  = '0;
    end else begin
      if (start_pulse) begin
        check("start_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          cur_mode = sb.pop_front();
          check("start_len", start_len, cur_mode);
        end else begin
          cur_mode = start_len;
        end
      end
      if (drain_rdreq) begin
        if (!in_drain) begin
          in_drain = 1'b1;
          dcnt     = 0;
          idx_bad  = 0;
        end
        if (drain_idx != 13'(dcnt)) idx_bad++;
        check("drain_len_at_idx", start_len, cur_mode);
        last_idx = drain_idx;
        dcnt++;
      end else if (in_drain) begin
        in_drain = 1'b0;
        exp_blk  = exp_blk + 8'd1;
        check("drain_len", dcnt, cur_mode ? LONG_N : SHORT_N);
        check("drain_idx_seq", idx_bad, 0);
        check("drain_last_idx", last_idx, (cur_mode ? LONG_N : SHORT_N) - 1);
        check("blk_count", blk_count, exp_blk);
        check("drain_idx_idle", drain_idx, 0);
      end
    end
  end

  // Encoder model: answers each start with computation_done, plus an occasional stray pulse in DRAIN.
  initial begin : responder
    int g;
    enc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (start_pulse && !reset) begin
        g = 0;
        while (hold_done && g < 20000) begin
          @(negedge clk);
          g++;
        end
        if (busy && !reset) begin
          repeat ((resp_delay > 0) ? resp_delay : int'($urandom_range(1, 25))) @(negedge clk);
          enc_done = 1'b1;
          @(negedge clk);
          enc_done = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            repeat (2) @(negedge clk);
            enc_done = 1'b1;
            @(negedge clk);
            enc_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_start_pulse"}, start_pulse, 0);
    check({tag, "_start_len"}, start_len, 0);
    check({tag, "_drain_rdreq"}, drain_rdreq, 0);
    check({tag, "_drain_idx"}, drain_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pend_count"}, pend_count, 0);
    check({tag, "_blk_count"}, blk_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((busy || pend_count != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) check("idle_timeout_busy", busy, 0);
  endtask

  task automatic wait_start(input int budget);
    int c;
    c = 0;
    while (!start_pulse && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) check("start_timeout", start_pulse, 1);
  endtask

  // One rising edge of blk_ready with the given mode; length_sel is scrambled after the edge.
  task automatic issue_req(input logic mode, input bit accepted);
    blk_ready = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    blk_ready  = 1'b1;
    length_sel = mode;
    if (accepted) sb.push_back(mode);
    @(negedge clk);
    length_sel = 1'($urandom_range(0, 1));
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  initial begin : global_limit
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    int   k, c;
    bit   exp_ovf;
    logic mode;
    logic queued_modes[5];
    logic [7:0] blk_before;

    reset      = 1'b1;
    blk_ready  = 1'b0;
    length_sel = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single short block with a fixed 20-cycle encoder, checking the t+2 start latency.
    resp_delay = 20;
    blk_ready  = 1'b1;
    length_sel = 1'b0;
    sb.push_back(1'b0);
    @(negedge clk);
    check("lat_t1_start", start_pulse, 0);
    check("lat_t1_pend", pend_count, 1);
    @(negedge clk);
    check("lat_t2_start", start_pulse, 1);
    check("lat_t2_pend", pend_count, 0);
    check("lat_t2_busy", busy, 1);
    wait_idle(3000);
    check("t1_blk_count", blk_count, 1);

    // Long block.
    resp_delay = 0;
    issue_req(1'b1, 1'b1);
    blk_ready = 1'b0;
    wait_idle(8000);
    check("t2_blk_count", blk_count, 2);

    // Level already high across reset release is not a request.
    blk_ready = 1'b1;
    apply_reset();
    repeat (10) @(negedge clk);
    check("held_busy", busy, 0);
    check("held_pend", pend_count, 0);
    blk_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Queueing: five edges while the first block is held in WAIT.
    hold_done = 1'b1;
    queued_modes = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    issue_req(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      issue_req(queued_modes[i], (i < 4));
      if (i == 3) begin
        check("q_pend_peak", pend_count, 4);
        check("q_ovf_before", overflow, 0);
      end
    end
    blk_ready = 1'b0;
    @(negedge clk);
    check("q_pend_full", pend_count, 4);
    check("q_overflow", overflow, 1);
    hold_done = 1'b0;
    wait_idle(30000);
    check("q_blk_count", blk_count, 5);
    check("q_sb_empty", sb.size(), 0);

    // Reset in the middle of a drain, with a request still queued.
    apply_reset();
    resp_delay = 5;
    issue_req(1'b0, 1'b1);
    issue_req(1'b1, 1'b1);
    blk_ready = 1'b0;
    c = 0;
    while (!(drain_rdreq && drain_idx == 13'd500) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("mid_reached_idx500", drain_idx, 500);
    check("mid_pend", pend_count, 1);
    reset = 1'b1;
    sb.delete();
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_mid_pend", pend_count, 0);
    check("post_mid_busy", busy, 0);
    resp_delay = 0;

    // Random bursts against the queue-capacity model.
    exp_ovf = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wait_idle(100);
      hold_done = 1'b1;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
        mode = ($urandom_range(0, 5) == 0);
        if (i >= 5) exp_ovf = 1'b1;
        issue_req(mode, (i < 5));
      end
      blk_ready = 1'b0;
      @(negedge clk);
      check("burst_pend", pend_count, ((k < 5) ? k : 5) - 1);
      check("burst_overflow", overflow, exp_ovf);
      hold_done = 1'b0;
      wait_idle(40000);
      check("burst_sb_empty", sb.size(), 0);
    end

    // WAIT without computation_done.
    wait_idle(100);
    blk_before = blk_count;
    hold_done = 1'b1;
    issue_req(1'b0, 1'b1);
    blk_ready = 1'b0;
    wait_start(10);
`ifdef ENC_WATCHDOG_EN
    c = 0;
    while (busy && c < 10000) begin
      c++;
      @(negedge clk);
    end
    check("wd_busy_cycles", c, 1 + TMO);
    check("wd_timeout_err", timeout_err, 1);
    check("wd_blk_count", blk_count, blk_before);
    check("wd_no_drain", drain_rdreq, 0);
    hold_done = 1'b0;
    repeat (40) @(negedge clk);
    check("wd_stays_idle", busy, 0);
`else
    repeat (300) @(negedge clk);
    check("nowd_still_busy", busy, 1);
    check("nowd_timeout_err", timeout_err, 0);
    hold_done = 1'b0;
    wait_idle(3000);
    check("nowd_blk_count", blk_count, blk_before + 8'd1);
`endif

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
